// File: rtl/rob_ss_m.sv
// Superscalar reorder buffer.
// A circular buffer of NUM_ROB entries that holds the new physical
// destination (T) and the displaced mapping (T_old) for each instruction.
// Dispatch is in order and all-or-nothing, up to WAYS lanes per cycle.
// Completions arrive out of order on C_PORTS ports. Retirement is a
// combinational in-order prefix of up to WAYS completed entries.
// Rollback squashes every entry younger than a kept branch entry.
// full and empty come from the occupancy counter and never from comparing
// head with tail, because head == tail holds both when empty and when full.
module rob_ss_m #(
    parameter int NUM_ROB = 32,
    parameter int NUM_PR  = 64,
    parameter int WAYS    = 2,
    parameter int C_PORTS = 2,
    localparam int PRW    = $clog2(NUM_PR),
    localparam int IDXW   = $clog2(NUM_ROB),
    localparam int CNTW   = IDXW + 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic [WAYS-1:0]         dispatch_valid,
    input  logic [WAYS*PRW-1:0]     T_in,
    input  logic [WAYS*PRW-1:0]     T_old_in,
    output logic                    dispatch_ready,
    output logic [WAYS*IDXW-1:0]    dispatch_idx,
    input  logic [C_PORTS-1:0]      complete_valid,
    input  logic [C_PORTS*IDXW-1:0] complete_idx,
    input  logic                    rollback_en,
    input  logic [IDXW-1:0]         rollback_idx,
    output logic [WAYS-1:0]         retire_valid,
    output logic [WAYS*PRW-1:0]     retire_T,
    output logic [WAYS*PRW-1:0]     retire_T_old,
    output logic [IDXW-1:0]         head_idx,
    output logic [CNTW-1:0]         count,
    output logic                    full,
    output logic                    empty
);

    // State: per-entry flags and payload, the two pointers and the occupancy
    logic [NUM_ROB-1:0] valid_q;
    logic [NUM_ROB-1:0] complete_q;
    logic [NUM_ROB-1:0] valid_d;
    logic [NUM_ROB-1:0] complete_d;
    logic [PRW-1:0]     t_q     [NUM_ROB];
    logic [PRW-1:0]     t_old_q [NUM_ROB];
    logic [IDXW-1:0]    head_q;
    logic [IDXW-1:0]    tail_q;
    logic [IDXW-1:0]    head_d;
    logic [IDXW-1:0]    tail_d;
    logic [CNTW-1:0]    count_q;
    logic [CNTW-1:0]    count_d;

    // Per-lane and per-port slot indices
    logic [IDXW-1:0]    disp_slot [WAYS];
    logic [IDXW-1:0]    ret_slot  [WAYS];
    logic [IDXW-1:0]    cmp_slot  [C_PORTS];

    logic [CNTW-1:0]    n_req;
    logic [CNTW-1:0]    free_slots;
    logic               disp_fire;

    logic [WAYS-1:0]    ret_mask;
    logic [CNTW-1:0]    ret_num;
    logic               ret_run;

    // Rollback bookkeeping. rb_dist is the branch's age relative to head;
    // rb_span is the number of entries younger than the branch.
    logic               rb_hit;
    logic [IDXW-1:0]    rb_dist;
    logic [IDXW-1:0]    rb_span;
    logic [CNTW-1:0]    rb_kept;
    logic [NUM_ROB-1:0] squash;

    assign rb_hit  = rollback_en && valid_q[rollback_idx];
    assign rb_dist = rollback_idx - head_q;
    assign rb_span = tail_q - rollback_idx - IDXW'(1);
    // The branch itself is valid, so at least one entry is kept (1..NUM_ROB).
    assign rb_kept = {1'b0, rb_dist} + CNTW'(1);

    for (genvar g = 0; g < WAYS; g++) begin : g_lane
        assign disp_slot[g] = tail_q + IDXW'(g);
        assign ret_slot[g]  = head_q + IDXW'(g);
        assign dispatch_idx[g*IDXW +: IDXW] = disp_slot[g];
        assign retire_T[g*PRW +: PRW]       = t_q[ret_slot[g]];
        assign retire_T_old[g*PRW +: PRW]   = t_old_q[ret_slot[g]];
    end

    for (genvar p = 0; p < C_PORTS; p++) begin : g_port
        assign cmp_slot[p] = complete_idx[p*IDXW +: IDXW];
    end

    // An entry is squashed when its distance past the branch falls within
    // the younger span; the mod-NUM_ROB subtraction handles wrap-around.
    for (genvar j = 0; j < NUM_ROB; j++) begin : g_sq
        logic [IDXW-1:0] rel;
        assign rel       = IDXW'(j) - rollback_idx - IDXW'(1);
        assign squash[j] = rel < rb_span;
    end

    // Count the lanes requested by dispatch
    always_comb begin
        n_req = '0;
        for (int i = 0; i < WAYS; i++) begin
            n_req = n_req + CNTW'(dispatch_valid[i]);
        end
    end

    // Space is judged before retirement, so a same-cycle retire never makes room
    assign free_slots     = CNTW'(NUM_ROB) - count_q;
    assign dispatch_ready = (free_slots >= n_req) && !rb_hit;
    assign disp_fire      = en && dispatch_ready && (|dispatch_valid);

    // Retire the in-order prefix of valid and complete entries. Retirement
    // never runs past a branch that is rolling back in the same cycle.
    always_comb begin
        ret_mask = '0;
        ret_num  = '0;
        ret_run  = en;
        for (int k = 0; k < WAYS; k++) begin
            if (ret_run && valid_q[ret_slot[k]] && complete_q[ret_slot[k]] &&
                !(rb_hit && (IDXW'(k) > rb_dist))) begin
                ret_mask[k] = 1'b1;
                ret_num     = ret_num + CNTW'(1);
            end else begin
                ret_run = 1'b0;
            end
        end
    end

    assign retire_valid = ret_mask;

    // Next-state flags. Order matters: completion first, then retire clears,
    // then squash clears (so a completion to a squashed entry is lost), then
    // dispatch sets.
    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        for (int p = 0; p < C_PORTS; p++) begin
            if (complete_valid[p] && valid_q[cmp_slot[p]]) begin
                complete_d[cmp_slot[p]] = 1'b1;
            end
        end
        for (int k = 0; k < WAYS; k++) begin
            if (ret_mask[k]) begin
                valid_d[ret_slot[k]]    = 1'b0;
                complete_d[ret_slot[k]] = 1'b0;
            end
        end
        if (rb_hit) begin
            valid_d    = valid_d & ~squash;
            complete_d = complete_d & ~squash;
        end
        if (disp_fire) begin
            for (int i = 0; i < WAYS; i++) begin
                if (dispatch_valid[i]) begin
                    valid_d[disp_slot[i]]    = 1'b1;
                    complete_d[disp_slot[i]] = 1'b0;
                end
            end
        end
    end

    // Next pointers and occupancy
    always_comb begin
        head_d  = head_q + ret_num[IDXW-1:0];
        tail_d  = tail_q;
        count_d = count_q - ret_num;
        if (rb_hit) begin
            tail_d  = rollback_idx + IDXW'(1);
            count_d = rb_kept - ret_num;
        end else if (disp_fire) begin
            tail_d  = tail_q + n_req[IDXW-1:0];
            count_d = count_q + n_req - ret_num;
        end
    end

    // Control state; nothing moves while en is low
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q    <= '0;
            complete_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else if (en) begin
            valid_q    <= valid_d;
            complete_q <= complete_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    // Payload storage; contents are meaningful only while the entry is valid
    always_ff @(posedge clock) begin
        if (disp_fire) begin
            for (int i = 0; i < WAYS; i++) begin
                if (dispatch_valid[i]) begin
                    t_q[disp_slot[i]]     <= T_in[i*PRW +: PRW];
                    t_old_q[disp_slot[i]] <= T_old_in[i*PRW +: PRW];
                end
            end
        end
    end

    assign head_idx = head_q;
    assign count    = count_q;
    assign full     = (count_q == CNTW'(NUM_ROB));
    assign empty    = (count_q == '0);

endmodule

// File: tb/tb_rob_ss_m.sv
// Bench for rob_ss_m. Dispatched payloads are queued in order, and every
// retiring lane is popped and compared. Occupancy, pointers and flags are
// compared against values that follow from the reorder-buffer rules.
module tb_rob_ss_m;

    localparam int PRW  = 6;
    localparam int IDXW = 5;
    localparam int CNTW = 6;
    localparam int NROB = 32;

    logic                 clock;
    logic                 reset;
    logic                 en;
    logic [1:0]           dispatch_valid;
    logic [2*PRW-1:0]     T_in;
    logic [2*PRW-1:0]     T_old_in;
    logic                 dispatch_ready;
    logic [2*IDXW-1:0]    dispatch_idx;
    logic [1:0]           complete_valid;
    logic [2*IDXW-1:0]    complete_idx;
    logic                 rollback_en;
    logic [IDXW-1:0]      rollback_idx;
    logic [1:0]           retire_valid;
    logic [2*PRW-1:0]     retire_T;
    logic [2*PRW-1:0]     retire_T_old;
    logic [IDXW-1:0]      head_idx;
    logic [CNTW-1:0]      count;
    logic                 full;
    logic                 empty;

    int n_checks = 0;
    int n_errors = 0;
    int exp_tail = 0;
    logic [2*PRW-1:0] exp_q [$];

    rob_ss_m #(.NUM_ROB(32), .NUM_PR(64), .WAYS(2), .C_PORTS(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .en             (en),
        .dispatch_valid (dispatch_valid),
        .T_in           (T_in),
        .T_old_in       (T_old_in),
        .dispatch_ready (dispatch_ready),
        .dispatch_idx   (dispatch_idx),
        .complete_valid (complete_valid),
        .complete_idx   (complete_idx),
        .rollback_en    (rollback_en),
        .rollback_idx   (rollback_idx),
        .retire_valid   (retire_valid),
        .retire_T       (retire_T),
        .retire_T_old   (retire_T_old),
        .head_idx       (head_idx),
        .count          (count),
        .full           (full),
        .empty          (empty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // One clock: at the falling edge, score any retiring lanes; return 1 after the rising edge
    task automatic tick();
        logic [2*PRW-1:0] e;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            if (retire_valid[k]) begin
                chk_val("sb_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk_val("ret_T", retire_T[k*PRW +: PRW], e[PRW-1:0]);
                    chk_val("ret_T_old", retire_T_old[k*PRW +: PRW], e[2*PRW-1:PRW]);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_dispatch(input int n, input int t0, input int to0,
                               input int t1, input int to1, input bit acc);
        dispatch_valid = (n == 2) ? 2'b11 : 2'b01;
        T_in     = {PRW'(t1), PRW'(t0)};
        T_old_in = {PRW'(to1), PRW'(to0)};
        #1;
        chk_val("disp_ready", dispatch_ready, acc);
        chk_val("disp_idx0", dispatch_idx[IDXW-1:0], exp_tail);
        if (n == 2) chk_val("disp_idx1", dispatch_idx[2*IDXW-1:IDXW], (exp_tail + 1) % NROB);
        tick();
        if (acc) begin
            exp_q.push_back({PRW'(to0), PRW'(t0)});
            if (n == 2) exp_q.push_back({PRW'(to1), PRW'(t1)});
            exp_tail = (exp_tail + n) % NROB;
        end
        dispatch_valid = 2'b00;
    endtask

    task automatic do_complete(input logic [1:0] v, input int i0, input int i1);
        complete_valid = v;
        complete_idx   = {IDXW'(i1), IDXW'(i0)};
        tick();
        complete_valid = 2'b00;
    endtask

    task automatic complete_range(input int start, input int n);
        for (int i = 0; i < n; i += 2) begin
            do_complete((i + 1 < n) ? 2'b11 : 2'b01, (start + i) % NROB, (start + i + 1) % NROB);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 200; c++) begin
            if (empty) break;
            tick();
        end
        chk_val("drain_empty", empty, 1);
    endtask

    task automatic fill_pairs(input int pairs, input int seed);
        for (int i = 0; i < pairs; i++) begin
            do_dispatch(2, (seed + i * 7) % 64, (seed + i * 5 + 1) % 64,
                        (seed + i * 7 + 3) % 64, (seed + i * 5 + 2) % 64, 1'b1);
        end
    endtask

    initial begin
        reset          = 1'b0;
        en             = 1'b0;
        dispatch_valid = '0;
        T_in           = '0;
        T_old_in       = '0;
        complete_valid = '0;
        complete_idx   = '0;
        rollback_en    = 1'b0;
        rollback_idx   = '0;

        // Reset state
        #12;
        chk_val("rst_retire", retire_valid, 0);
        chk_val("rst_empty", empty, 1);
        chk_val("rst_full", full, 0);
        chk_val("rst_ready", dispatch_ready, 1);
        chk_val("rst_head", head_idx, 0);
        chk_val("rst_count", count, 0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        en = 1'b1;

        // Two-lane dispatch
        do_dispatch(2, 5, 1, 6, 2, 1'b1);
        chk_val("t1_count", count, 2);
        chk_val("t1_retire", retire_valid, 0);

        // Out-of-order completion, then a two-wide retire
        do_complete(2'b01, 1, 0);
        chk_val("t2_no_retire", retire_valid, 0);
        do_complete(2'b01, 0, 0);
        chk_val("t2_retire", retire_valid, 2'b11);
        chk_val("t2_T", retire_T, (6 << 6) | 5);
        chk_val("t2_T_old", retire_T_old, (2 << 6) | 1);
        tick();
        chk_val("t2_head", head_idx, 2);
        chk_val("t2_empty", empty, 1);

        // Fill to capacity; a request while full is refused
        fill_pairs(16, 10);
        chk_val("t3_full", full, 1);
        chk_val("t3_count", count, 32);
        do_dispatch(1, 40, 41, 0, 0, 1'b0);
        chk_val("t3_count_kept", count, 32);
        do_complete(2'b01, 2, 2);
        chk_val("t3_retire", retire_valid, 2'b01);
        tick();
        chk_val("t3_count31", count, 31);
        dispatch_valid = 2'b01;
        #1;
        chk_val("t3_ready", dispatch_ready, 1);
        dispatch_valid = 2'b00;
        complete_range(3, 31);
        drain();
        chk_val("t3_head", head_idx, 2);

        // Move head to 30, then dispatch across the wrap point
        fill_pairs(14, 20);
        complete_range(2, 28);
        drain();
        chk_val("t4_head30", head_idx, 30);
        do_dispatch(2, 11, 12, 13, 14, 1'b1);
        do_dispatch(2, 15, 16, 17, 18, 1'b1);
        chk_val("t4_tail", dispatch_idx[IDXW-1:0], 2);
        chk_val("t4_count", count, 4);
        complete_range(30, 4);
        drain();
        chk_val("t4_head", head_idx, 2);

        // Rollback: entries 3..9, branch at 5, dispatch request in the same cycle
        do_dispatch(1, 50, 51, 0, 0, 1'b1);
        complete_range(2, 1);
        drain();
        fill_pairs(3, 30);
        do_dispatch(1, 60, 61, 0, 0, 1'b1);
        chk_val("t5_count7", count, 7);
        rollback_en    = 1'b1;
        rollback_idx   = 5'd5;
        dispatch_valid = 2'b11;
        T_in           = {6'd33, 6'd32};
        T_old_in       = {6'd35, 6'd34};
        #1;
        chk_val("t5_ready_blocked", dispatch_ready, 0);
        tick();
        rollback_en    = 1'b0;
        dispatch_valid = 2'b00;
        for (int i = 0; i < 4; i++) void'(exp_q.pop_back());
        exp_tail = 6;
        chk_val("t5_count", count, 3);
        chk_val("t5_tail", dispatch_idx[IDXW-1:0], 6);
        chk_val("t5_head", head_idx, 3);
        do_complete(2'b01, 7, 7);
        chk_val("t5_count_after_cmp", count, 3);
        chk_val("t5_no_retire", retire_valid, 0);
        do_dispatch(2, 44, 45, 46, 47, 1'b1);
        complete_range(3, 4);
        tick();
        tick();
        tick();
        chk_val("t5_idx7_pending", count, 1);
        chk_val("t5_head7", head_idx, 7);
        complete_range(7, 1);
        drain();

        // Reset in the middle of operation with a retire pending
        fill_pairs(5, 3);
        chk_val("t6_count10", count, 10);
        do_complete(2'b01, 8, 8);
        chk_val("t6_retire_pend", retire_valid, 2'b01);
        #2;
        reset = 1'b0;
        #1;
        chk_val("t6_rst_retire", retire_valid, 0);
        chk_val("t6_rst_count", count, 0);
        chk_val("t6_rst_empty", empty, 1);
        chk_val("t6_rst_head", head_idx, 0);
        exp_q.delete();
        exp_tail = 0;
        #2;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // en low freezes everything despite requests
        do_dispatch(2, 21, 22, 23, 24, 1'b1);
        do_complete(2'b01, 0, 0);
        en             = 1'b0;
        dispatch_valid = 2'b11;
        complete_valid = 2'b01;
        complete_idx   = {5'd0, 5'd1};
        rollback_en    = 1'b1;
        rollback_idx   = 5'd0;
        tick();
        en             = 1'b1;
        dispatch_valid = 2'b00;
        complete_valid = 2'b00;
        rollback_en    = 1'b0;
        #1;
        chk_val("t6_en0_count", count, 2);
        chk_val("t6_en0_head", head_idx, 0);
        chk_val("t6_en0_tail", dispatch_idx[IDXW-1:0], 2);
        chk_val("t6_en0_retire", retire_valid, 2'b01);
        tick();
        do_complete(2'b01, 1, 1);
        drain();
        chk_val("end_count", count, 0);
        chk_val("end_sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
